// File: rtl/serpent_key_schedule.sv
// Serpent key schedule: expands a padded 256-bit key into 33 bitsliced 128-bit subkeys, one prekey word per clock.
// 132 cycles after start; o_key is a zero-latency combinational read of the subkey store.
module serpent_key_schedule #(
  parameter logic [31:0] PHI         = 32'h9E3779B9,
  parameter int          NUM_SUBKEYS = 33
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic         i_start,
  input  logic [255:0] i_user_key,
  input  logic [5:0]   i_address,
  output logic [127:0] o_key,
  output logic         o_subkey_valid,
  output logic         o_busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [7:0] LAST_WORD = 8'd131;

  // S-box tables packed with entry 0 in the low nibble
  localparam logic [63:0] SBOX0 = 64'hC907_24DE_B56A_1F83;
  localparam logic [63:0] SBOX1 = 64'h43D6_8EB1_A509_72CF;
  localparam logic [63:0] SBOX2 = 64'h25B0_4E1D_FAC3_9768;
  localparam logic [63:0] SBOX3 = 64'hE57A_421D_369C_8BF0;
  localparam logic [63:0] SBOX4 = 64'hD7E9_A452_6B0C_38F1;
  localparam logic [63:0] SBOX5 = 64'h176D_8E30_C9A4_B25F;
  localparam logic [63:0] SBOX6 = 64'h0A3D_F19E_B648_5C27;
  localparam logic [63:0] SBOX7 = 64'h6539_AC47_B28E_0FD1;

  state_t        state;
  logic [7:0]    cnt;
  logic [31:0]   win  [0:7];
  logic [127:0]  keys [0:NUM_SUBKEYS-1];

  logic [31:0]   mix;
  logic [31:0]   new_word;
  logic [5:0]    kidx;
  logic [2:0]    box;
  logic [127:0]  sk;

  function automatic logic [3:0] sbox(input logic [2:0] sel, input logic [3:0] x);
    logic [63:0] tab;
    case (sel)
      3'd0:    tab = SBOX0;
      3'd1:    tab = SBOX1;
      3'd2:    tab = SBOX2;
      3'd3:    tab = SBOX3;
      3'd4:    tab = SBOX4;
      3'd5:    tab = SBOX5;
      3'd6:    tab = SBOX6;
      default: tab = SBOX7;
    endcase
    return tab[{x, 2'b00} +: 4];
  endfunction

  // win[0] holds w(i-8), win[7] holds w(i-1)
  always_comb begin
    mix      = win[0] ^ win[3] ^ win[5] ^ win[7] ^ PHI ^ {24'd0, cnt};
    new_word = {mix[20:0], mix[31:21]};
    kidx     = cnt[7:2];
    box      = 3'd3 - kidx[2:0];
  end

  // Subkey from w(4k)=win[5], w(4k+1)=win[6], w(4k+2)=win[7], w(4k+3)=new_word
  always_comb begin
    logic [3:0] nib;
    logic [3:0] sout;
    sk   = '0;
    nib  = '0;
    sout = '0;
    for (int j = 0; j < 32; j++) begin
      nib          = {new_word[j], win[7][j], win[6][j], win[5][j]};
      sout         = sbox(box, nib);
      sk[j]        = sout[0];
      sk[32 + j]   = sout[1];
      sk[64 + j]   = sout[2];
      sk[96 + j]   = sout[3];
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state          <= IDLE;
      cnt            <= '0;
      o_busy         <= 1'b0;
      o_subkey_valid <= 1'b0;
      for (int e = 0; e < 8; e++) win[e] <= '0;
      for (int e = 0; e < NUM_SUBKEYS; e++) keys[e] <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (i_start) begin
            state          <= EXPAND;
            cnt            <= '0;
            o_busy         <= 1'b1;
            o_subkey_valid <= 1'b0;
            for (int e = 0; e < 8; e++) win[e] <= i_user_key[32*e +: 32];
          end
        end
        EXPAND: begin
          for (int e = 0; e < 7; e++) win[e] <= win[e+1];
          win[7] <= new_word;
          cnt    <= cnt + 8'd1;
          if (cnt[1:0] == 2'b11) keys[kidx] <= sk;
          if (cnt == LAST_WORD) begin
            state          <= DONE;
            o_busy         <= 1'b0;
            o_subkey_valid <= 1'b1;
          end
        end
        default: begin
          state          <= IDLE;
          o_busy         <= 1'b0;
          o_subkey_valid <= 1'b0;
        end
      endcase
    end
  end

  // Addresses past the last subkey read as zero
  always_comb begin
    o_key = '0;
    if (i_address < 6'(NUM_SUBKEYS)) o_key = keys[i_address];
  end

endmodule
